// File: rtl/csr_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | csr_unit_pkg : shared encodings, CSR addresses, bit indices, cause codes    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package csr_unit_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'd0,
        CSR_OP_WRITE = 2'd1,
        CSR_OP_SET   = 2'd2,
        CSR_OP_CLEAR = 2'd3
    } csr_op_t;

    localparam logic [11:0] c_addr_mstatus   = 12'h300;
    localparam logic [11:0] c_addr_misa      = 12'h301;
    localparam logic [11:0] c_addr_mie       = 12'h304;
    localparam logic [11:0] c_addr_mtvec     = 12'h305;
    localparam logic [11:0] c_addr_mscratch  = 12'h340;
    localparam logic [11:0] c_addr_mepc      = 12'h341;
    localparam logic [11:0] c_addr_mcause    = 12'h342;
    localparam logic [11:0] c_addr_mtval     = 12'h343;
    localparam logic [11:0] c_addr_mip       = 12'h344;
    localparam logic [11:0] c_addr_mcycle    = 12'hB00;
    localparam logic [11:0] c_addr_minstret  = 12'hB02;
    localparam logic [11:0] c_addr_mcycleh   = 12'hB80;
    localparam logic [11:0] c_addr_minstreth = 12'hB82;
    localparam logic [11:0] c_addr_cycle     = 12'hC00;
    localparam logic [11:0] c_addr_instret   = 12'hC02;
    localparam logic [11:0] c_addr_cycleh    = 12'hC80;
    localparam logic [11:0] c_addr_instreth  = 12'hC82;
    localparam logic [11:0] c_addr_mvendorid = 12'hF11;
    localparam logic [11:0] c_addr_marchid   = 12'hF12;
    localparam logic [11:0] c_addr_mimpid    = 12'hF13;
    localparam logic [11:0] c_addr_mhartid   = 12'hF14;

    localparam int c_mstatus_mie  = 3;
    localparam int c_mstatus_mpie = 7;
    localparam int c_mip_msi      = 3;
    localparam int c_mip_mti      = 7;
    localparam int c_mip_mei      = 11;

    localparam logic [31:0] c_mie_writable_mask = 32'h0000_0888;
    localparam logic [31:0] c_misa_value        = 32'h4000_0100;

    localparam logic [31:0] c_cause_illegal_instr = 32'd2;
    localparam logic [31:0] c_cause_breakpoint    = 32'd3;
    localparam logic [31:0] c_cause_ecall_m       = 32'd11;

    localparam logic [30:0] c_irq_code_msi = 31'd3;
    localparam logic [30:0] c_irq_code_mti = 31'd7;
    localparam logic [30:0] c_irq_code_mei = 31'd11;

    // External beats software beats timer; no pending source yields zero.
    function automatic logic [31:0] irq_cause_of(input logic [31:0] pend);
        logic [31:0] cause;
        cause = 32'd0;
        if (pend[c_mip_mei]) begin
            cause = {1'b1, c_irq_code_mei};
        end else if (pend[c_mip_msi]) begin
            cause = {1'b1, c_irq_code_msi};
        end else if (pend[c_mip_mti]) begin
            cause = {1'b1, c_irq_code_mti};
        end
        return cause;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | csr_unit_if : pipeline <-> CSR unit signal bundle                           |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface csr_unit_if;

    logic [1:0]  csr_op;
    logic        csr_source;
    logic [11:0] csr_addr;
    logic [4:0]  rs1_idx;
    logic [31:0] rs1_data;
    logic        exc_request;
    logic [31:0] exc_cause;
    logic        exc_ret;
    logic [31:0] pc;
    logic        instr_retired;
    logic        irq_timer;
    logic        irq_external;
    logic        irq_software;

    logic [31:0] csr_rdata;
    logic        illegal_csr;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        irq_req;
    logic [31:0] irq_cause;

    modport master (
        output csr_op, csr_source, csr_addr, rs1_idx, rs1_data,
        output exc_request, exc_cause, exc_ret, pc, instr_retired,
        output irq_timer, irq_external, irq_software,
        input  csr_rdata, illegal_csr, mtvec_out, mepc_out, irq_req, irq_cause
    );

    modport slave (
        input  csr_op, csr_source, csr_addr, rs1_idx, rs1_data,
        input  exc_request, exc_cause, exc_ret, pc, instr_retired,
        input  irq_timer, irq_external, irq_software,
        output csr_rdata, illegal_csr, mtvec_out, mepc_out, irq_req, irq_cause
    );

endinterface
`default_nettype wire

// File: rtl/csr_unit_counter64.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | csr_counter64 : 64-bit counter with increment enable and lo/hi write ports  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_count
);

    logic [63:0] r_count;
    logic [63:0] w_count_nxt;

    // A write to one half freezes the other half and suppresses the increment.
    always_comb begin
        w_count_nxt = r_count;
        if (i_wr_lo) begin
            w_count_nxt[31:0] = i_wdata;
        end else if (i_wr_hi) begin
            w_count_nxt[63:32] = i_wdata;
        end else if (i_inc) begin
            w_count_nxt = r_count + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 64'd0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/csr_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | csr_unit : machine-mode CSR file and trap sequencer for the RV32I hart      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module csr_unit
    import csr_unit_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic      clk,
    input  logic      rst,
    csr_unit_if.slave bus
);

    localparam logic [31:0] c_mtvec_reset = {MTVEC_RESET[31:2], 2'b00};

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;

    logic        w_mstatus_mie_nxt;
    logic        w_mstatus_mpie_nxt;
    logic [31:0] w_mie_nxt;
    logic [31:0] w_mtvec_nxt;
    logic [31:0] w_mscratch_nxt;
    logic [31:0] w_mepc_nxt;
    logic [31:0] w_mcause_nxt;
    logic [31:0] w_mtval_nxt;

    csr_op_t     w_op;
    logic [31:0] w_mstatus;
    logic [31:0] w_mip;
    logic [31:0] w_irq_pend;
    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;
    logic [31:0] w_rval;
    logic        w_impl;
    logic [31:0] w_operand;
    logic [31:0] w_wval;
    logic        w_we;
    logic        w_illegal;
    logic        w_wr_commit;
    logic        w_unused;

    assign w_op     = csr_op_t'(bus.csr_op);
    assign w_unused = ^bus.pc[1:0];

    always_comb begin
        w_mstatus                 = 32'd0;
        w_mstatus[c_mstatus_mie]  = r_mstatus_mie;
        w_mstatus[c_mstatus_mpie] = r_mstatus_mpie;
        w_mstatus[12:11]          = 2'b11;
    end

    always_comb begin
        w_mip            = 32'd0;
        w_mip[c_mip_msi] = bus.irq_software;
        w_mip[c_mip_mti] = bus.irq_timer;
        w_mip[c_mip_mei] = bus.irq_external;
    end

    always_comb begin
        w_impl = 1'b1;
        w_rval = 32'd0;
        case (bus.csr_addr)
            c_addr_mstatus:   w_rval = w_mstatus;
            c_addr_misa:      w_rval = c_misa_value;
            c_addr_mie:       w_rval = r_mie;
            c_addr_mtvec:     w_rval = r_mtvec;
            c_addr_mscratch:  w_rval = r_mscratch;
            c_addr_mepc:      w_rval = r_mepc;
            c_addr_mcause:    w_rval = r_mcause;
            c_addr_mtval:     w_rval = r_mtval;
            c_addr_mip:       w_rval = w_mip;
            c_addr_mcycle,
            c_addr_cycle:     w_rval = w_mcycle[31:0];
            c_addr_mcycleh,
            c_addr_cycleh:    w_rval = w_mcycle[63:32];
            c_addr_minstret,
            c_addr_instret:   w_rval = w_minstret[31:0];
            c_addr_minstreth,
            c_addr_instreth:  w_rval = w_minstret[63:32];
            c_addr_mvendorid,
            c_addr_marchid,
            c_addr_mimpid:    w_rval = 32'd0;
            c_addr_mhartid:   w_rval = HART_ID;
            default:          w_impl = 1'b0;
        endcase
    end

    assign w_operand = bus.csr_source ? {27'd0, bus.rs1_idx} : bus.rs1_data;

    always_comb begin
        w_wval = w_operand;
        case (w_op)
            CSR_OP_SET:   w_wval = w_rval | w_operand;
            CSR_OP_CLEAR: w_wval = w_rval & ~w_operand;
            default:      w_wval = w_operand;
        endcase
    end

    // Set/clear with rs1 field zero never writes, so read-only CSRs stay readable that way.
    assign w_we = (w_op == CSR_OP_WRITE) ||
                  (((w_op == CSR_OP_SET) || (w_op == CSR_OP_CLEAR)) && (bus.rs1_idx != 5'd0));

    assign w_illegal = (w_op != CSR_OP_NONE) &&
                       (!w_impl || (w_we && (bus.csr_addr[11:10] == 2'b11)));

    assign w_wr_commit = w_we && !w_illegal && !bus.exc_request && !bus.exc_ret;

    always_comb begin
        w_mstatus_mie_nxt  = r_mstatus_mie;
        w_mstatus_mpie_nxt = r_mstatus_mpie;
        w_mie_nxt          = r_mie;
        w_mtvec_nxt        = r_mtvec;
        w_mscratch_nxt     = r_mscratch;
        w_mepc_nxt         = r_mepc;
        w_mcause_nxt       = r_mcause;
        w_mtval_nxt        = r_mtval;
        if (bus.exc_request) begin
            w_mepc_nxt         = {bus.pc[31:2], 2'b00};
            w_mcause_nxt       = bus.exc_cause;
            w_mtval_nxt        = 32'd0;
            w_mstatus_mpie_nxt = r_mstatus_mie;
            w_mstatus_mie_nxt  = 1'b0;
        end else if (bus.exc_ret) begin
            w_mstatus_mie_nxt  = r_mstatus_mpie;
            w_mstatus_mpie_nxt = 1'b1;
        end else if (w_wr_commit) begin
            case (bus.csr_addr)
                c_addr_mstatus: begin
                    w_mstatus_mie_nxt  = w_wval[c_mstatus_mie];
                    w_mstatus_mpie_nxt = w_wval[c_mstatus_mpie];
                end
                c_addr_mie:      w_mie_nxt      = w_wval & c_mie_writable_mask;
                c_addr_mtvec:    w_mtvec_nxt    = {w_wval[31:2], 2'b00};
                c_addr_mscratch: w_mscratch_nxt = w_wval;
                c_addr_mepc:     w_mepc_nxt     = {w_wval[31:2], 2'b00};
                c_addr_mcause:   w_mcause_nxt   = w_wval;
                c_addr_mtval:    w_mtval_nxt    = w_wval;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= 32'd0;
            r_mtvec        <= c_mtvec_reset;
            r_mscratch     <= 32'd0;
            r_mepc         <= 32'd0;
            r_mcause       <= 32'd0;
            r_mtval        <= 32'd0;
        end else begin
            r_mstatus_mie  <= w_mstatus_mie_nxt;
            r_mstatus_mpie <= w_mstatus_mpie_nxt;
            r_mie          <= w_mie_nxt;
            r_mtvec        <= w_mtvec_nxt;
            r_mscratch     <= w_mscratch_nxt;
            r_mepc         <= w_mepc_nxt;
            r_mcause       <= w_mcause_nxt;
            r_mtval        <= w_mtval_nxt;
        end
    end

    csr_counter64 u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (1'b1),
        .i_wr_lo (w_wr_commit && (bus.csr_addr == c_addr_mcycle)),
        .i_wr_hi (w_wr_commit && (bus.csr_addr == c_addr_mcycleh)),
        .i_wdata (w_wval),
        .o_count (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (bus.instr_retired),
        .i_wr_lo (w_wr_commit && (bus.csr_addr == c_addr_minstret)),
        .i_wr_hi (w_wr_commit && (bus.csr_addr == c_addr_minstreth)),
        .i_wdata (w_wval),
        .o_count (w_minstret)
    );

    assign w_irq_pend = r_mie & w_mip;

    assign bus.csr_rdata   = w_illegal ? 32'd0 : w_rval;
    assign bus.illegal_csr = w_illegal;
    assign bus.mtvec_out   = {r_mtvec[31:2], 2'b00};
    assign bus.mepc_out    = r_mepc;
    assign bus.irq_req     = r_mstatus_mie && (w_irq_pend != 32'd0);
    assign bus.irq_cause   = irq_cause_of(w_irq_pend);

endmodule
`default_nettype wire

// File: tb/tb_csr_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_csr_unit : directed + random stimulus against a behavioural CSR model    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_csr_unit;

    localparam logic [31:0] c_hart_id = 32'd5;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    csr_unit_if bus ();

    csr_unit #(
        .MTVEC_RESET (32'h0000_0103),
        .HART_ID     (c_hart_id)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: architectural CSR contents as plain variables.
    bit          m_valid;
    bit          m_mie_g;
    bit          m_mpie;
    logic [31:0] m_mie;
    logic [31:0] m_mtvec;
    logic [31:0] m_mscratch;
    logic [31:0] m_mepc;
    logic [31:0] m_mcause;
    logic [31:0] m_mtval;
    bit   [63:0] m_cyc;
    bit   [63:0] m_ins;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mip_now();
        return (32'(bus.irq_software) << 3) | (32'(bus.irq_timer) << 7) |
               (32'(bus.irq_external) << 11);
    endfunction

    function automatic void model_read(input logic [11:0] a, output bit impl, output logic [31:0] v);
        impl = 1'b1;
        v    = 32'd0;
        case (a)
            12'h300: v = 32'h0000_1800 | (32'(m_mie_g) << 3) | (32'(m_mpie) << 7);
            12'h301: v = 32'h4000_0100;
            12'h304: v = m_mie;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'h344: v = mip_now();
            12'hB00, 12'hC00: v = m_cyc[31:0];
            12'hB80, 12'hC80: v = m_cyc[63:32];
            12'hB02, 12'hC02: v = m_ins[31:0];
            12'hB82, 12'hC82: v = m_ins[63:32];
            12'hF11, 12'hF12, 12'hF13: v = 32'd0;
            12'hF14: v = c_hart_id;
            default: impl = 1'b0;
        endcase
    endfunction

    // One clock: compare all outputs mid-cycle, then advance the model at the edge.
    task automatic tick();
        bit          impl, we, ill, wr;
        logic [31:0] old, opnd, nv, pend, exp_cause;
        @(negedge clk);
        model_read(bus.csr_addr, impl, old);
        opnd = bus.csr_source ? {27'd0, bus.rs1_idx} : bus.rs1_data;
        case (bus.csr_op)
            2'd2:    nv = old | opnd;
            2'd3:    nv = old & ~opnd;
            default: nv = opnd;
        endcase
        we  = (bus.csr_op == 2'd1) || (bus.csr_op >= 2'd2 && bus.rs1_idx != 5'd0);
        ill = (bus.csr_op != 2'd0) && (!impl || (we && bus.csr_addr[11:10] == 2'b11));
        pend = m_mie & mip_now();
        if (pend[11])     exp_cause = 32'h8000_000B;
        else if (pend[3]) exp_cause = 32'h8000_0003;
        else if (pend[7]) exp_cause = 32'h8000_0007;
        else              exp_cause = 32'd0;
        if (m_valid) begin
            check_value("csr_rdata",   bus.csr_rdata, ill ? 32'd0 : old);
            check_value("illegal_csr", 32'(bus.illegal_csr), 32'(ill));
            check_value("mtvec_out",   bus.mtvec_out, m_mtvec);
            check_value("mepc_out",    bus.mepc_out, m_mepc);
            check_value("irq_req",     32'(bus.irq_req), 32'(m_mie_g && pend != 0));
            check_value("irq_cause",   bus.irq_cause, exp_cause);
        end
        @(posedge clk);
        wr = we && !ill && !bus.exc_request && !bus.exc_ret;
        if (rst) begin
            m_valid = 1'b1;
            m_mie_g = 1'b0; m_mpie = 1'b0; m_mie = 0; m_mtvec = 32'h0000_0100;
            m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
            m_cyc = 0; m_ins = 0;
        end else begin
            if (bus.exc_request) begin
                m_mepc   = bus.pc & ~32'd3;
                m_mcause = bus.exc_cause;
                m_mtval  = 0;
                m_mpie   = m_mie_g;
                m_mie_g  = 1'b0;
            end else if (bus.exc_ret) begin
                m_mie_g = m_mpie;
                m_mpie  = 1'b1;
            end else if (wr) begin
                case (bus.csr_addr)
                    12'h300: begin m_mie_g = nv[3]; m_mpie = nv[7]; end
                    12'h304: m_mie      = nv & 32'h888;
                    12'h305: m_mtvec    = nv & ~32'd3;
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc     = nv & ~32'd3;
                    12'h342: m_mcause   = nv;
                    12'h343: m_mtval    = nv;
                    default: ;
                endcase
            end
            if (wr && bus.csr_addr == 12'hB00)      m_cyc[31:0]  = nv;
            else if (wr && bus.csr_addr == 12'hB80) m_cyc[63:32] = nv;
            else                                    m_cyc        = m_cyc + 64'd1;
            if (wr && bus.csr_addr == 12'hB02)      m_ins[31:0]  = nv;
            else if (wr && bus.csr_addr == 12'hB82) m_ins[63:32] = nv;
            else if (bus.instr_retired)             m_ins        = m_ins + 64'd1;
        end
        #1;
    endtask

    task automatic set_idle();
        bus.csr_op = 2'd0; bus.csr_source = 1'b0; bus.csr_addr = 12'h340;
        bus.rs1_idx = 5'd0; bus.rs1_data = 32'd0;
        bus.exc_request = 1'b0; bus.exc_cause = 32'd0; bus.exc_ret = 1'b0;
        bus.pc = 32'd0; bus.instr_retired = 1'b0;
        bus.irq_timer = 1'b0; bus.irq_external = 1'b0; bus.irq_software = 1'b0;
    endtask

    task automatic csr_access(input logic [1:0] op, input logic src, input logic [11:0] addr,
                              input logic [4:0] idx, input logic [31:0] data);
        bus.csr_op = op; bus.csr_source = src; bus.csr_addr = addr;
        bus.rs1_idx = idx; bus.rs1_data = data;
    endtask

    logic [11:0] addr_pool [24] = '{
        12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
        12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
        12'hC82, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'h345, 12'hFFF
    };

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_valid  = 1'b0;
        rst      = 1'b1;
        set_idle();
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        bus.csr_addr = 12'h305; #1;
        check_value("rst_mtvec", bus.csr_rdata, 32'h0000_0100);
        bus.csr_addr = 12'h300; #1;
        check_value("rst_mstatus", bus.csr_rdata, 32'h0000_1800);
        check_value("rst_irq_req", 32'(bus.irq_req), 32'd0);
        check_value("rst_mepc_out", bus.mepc_out, 32'd0);
        tick();

        // CSRRW returns the old value, then the new one; CSRRSI zimm=0 is a pure read
        csr_access(2'd1, 1'b0, 12'h340, 5'd7, 32'hDEAD_BEEF); #1;
        check_value("rw_old", bus.csr_rdata, 32'd0);
        tick();
        csr_access(2'd2, 1'b1, 12'h340, 5'd0, 32'hFFFF_FFFF); #1;
        check_value("rw_new", bus.csr_rdata, 32'hDEAD_BEEF);
        tick();
        set_idle(); #1;
        check_value("rsi0_keep", bus.csr_rdata, 32'hDEAD_BEEF);
        tick();

        // Trap entry and MRET
        csr_access(2'd2, 1'b0, 12'h300, 5'd1, 32'h8);
        tick();
        set_idle();
        bus.exc_request = 1'b1; bus.exc_cause = 32'd11; bus.pc = 32'h1236;
        tick();
        set_idle();
        bus.csr_addr = 12'h341; #1;
        check_value("trap_mepc", bus.csr_rdata, 32'h1234);
        bus.csr_addr = 12'h342; #1;
        check_value("trap_mcause", bus.csr_rdata, 32'd11);
        bus.csr_addr = 12'h300; #1;
        check_value("trap_mstatus", bus.csr_rdata, 32'h0000_1880);
        bus.exc_ret = 1'b1;
        tick();
        set_idle();
        bus.csr_addr = 12'h300; #1;
        check_value("mret_mstatus", bus.csr_rdata, 32'h0000_1888);

        // Interrupt priority
        csr_access(2'd1, 1'b0, 12'h304, 5'd2, 32'hFFFF_FFFF);
        tick();
        set_idle();
        bus.irq_timer = 1'b1; bus.irq_external = 1'b1; #1;
        check_value("irq_req_on", 32'(bus.irq_req), 32'd1);
        check_value("irq_cause_mei", bus.irq_cause, 32'h8000_000B);
        bus.irq_external = 1'b0; #1;
        check_value("irq_cause_mti", bus.irq_cause, 32'h8000_0007);
        tick();
        set_idle();

        // Illegal accesses
        csr_access(2'd1, 1'b0, 12'hC00, 5'd3, 32'h1234_5678); #1;
        check_value("ill_c00", 32'(bus.illegal_csr), 32'd1);
        tick();
        csr_access(2'd1, 1'b0, 12'h7C0, 5'd3, 32'h1234_5678); #1;
        check_value("ill_7c0", 32'(bus.illegal_csr), 32'd1);
        tick();
        csr_access(2'd2, 1'b0, 12'hF14, 5'd0, 32'hFFFF_FFFF); #1;
        check_value("hartid_legal", 32'(bus.illegal_csr), 32'd0);
        check_value("hartid_val", bus.csr_rdata, c_hart_id);
        tick();

        // Trap outranks a simultaneous CSR write
        csr_access(2'd1, 1'b0, 12'h340, 5'd4, 32'h1234_5678);
        bus.exc_request = 1'b1; bus.exc_cause = 32'd2; bus.pc = 32'h40;
        tick();
        set_idle(); #1;
        check_value("trap_blocks_wr", bus.csr_rdata, 32'hDEAD_BEEF);
        tick();

        // mcycle carry into mcycleh
        csr_access(2'd1, 1'b0, 12'hB80, 5'd1, 32'd0);
        tick();
        csr_access(2'd1, 1'b0, 12'hB00, 5'd1, 32'hFFFF_FFFF);
        tick();
        set_idle(); bus.csr_addr = 12'hB00; #1;
        check_value("mcycle_pre", bus.csr_rdata, 32'hFFFF_FFFF);
        tick();
        bus.csr_addr = 12'hB00; #1;
        check_value("mcycle_wrap", bus.csr_rdata, 32'd0);
        tick();
        bus.csr_addr = 12'hB80; #1;
        check_value("mcycleh_carry", bus.csr_rdata, 32'd1);
        tick();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus.csr_op        = 2'($urandom_range(0, 3));
            bus.csr_source    = 1'($urandom_range(0, 1));
            bus.csr_addr      = addr_pool[$urandom_range(0, 23)];
            bus.rs1_idx       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            bus.rs1_data      = $urandom;
            bus.exc_request   = ($urandom_range(0, 15) == 0);
            bus.exc_cause     = $urandom;
            bus.exc_ret       = ($urandom_range(0, 15) == 0);
            bus.pc            = $urandom;
            bus.instr_retired = 1'($urandom_range(0, 1));
            bus.irq_timer     = 1'($urandom_range(0, 1));
            bus.irq_external  = 1'($urandom_range(0, 1));
            bus.irq_software  = 1'($urandom_range(0, 1));
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
